// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter4
//  Purpose  : Four-way round-robin arbiter for a single shared resource.
//             Issues a registered one-hot grant that is held while the owner
//             keeps its request high. On release, priority rotates starting
//             just after the releasing owner, with no idle bubble if another
//             requester is waiting. Also exports the combinational OR of all
//             requests for upstream wake-up logic.
//
//  Ports    : clk         - system clock, rising edge
//             rst         - synchronous, active-high reset
//             req[3:0]    - request vector, held high for the whole use
//             grant[3:0]  - registered one-hot grant, zero when idle
//             grant_id    - binary index of owner (valid with grant_valid)
//             grant_valid - registered, equals |grant
//             any_req     - combinational OR of req
//             revoke      - registered one-cycle pulse on forced rotation
//
//  Options  : RR_HOLD_LIMIT_EN - when defined, an owner holding for
//             HOLD_LIMIT consecutive cycles is forced to hand over to a
//             waiting requester (revoke pulses for that cycle). When not
//             defined, the hold counter is absent and revoke is tied low.
//
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4 #(
    parameter int HOLD_LIMIT = 8,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       any_req,
    output logic       revoke
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Reject parameter sets where the hold counter cannot reach its limit.
    if ((HOLD_LIMIT < 2) || (HOLD_LIMIT > 255) || ((64'd1 << CW) <= 64'(HOLD_LIMIT)))
    begin : g_param_check
        $error("rr_arbiter4: HOLD_LIMIT must be 2..255 and fit in CW bits");
    end

    // First requester found scanning ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
    // Callers only use the result when r is non-zero.
    function automatic logic [1:0] pick(input logic [1:0] ptr, input logic [3:0] r);
        logic [1:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    logic [0:0] r_state;
    logic [3:0] r_grant;
    logic [1:0] r_grant_id;
    logic       r_grant_valid;
    logic [1:0] r_last;
    logic       r_revoke;

    logic [0:0] w_state_nxt;
    logic [3:0] w_grant_nxt;
    logic [1:0] w_grant_id_nxt;
    logic [1:0] w_last_nxt;
    logic       w_revoke_nxt;
    logic [3:0] w_others;
    logic [1:0] w_win;

`ifdef RR_HOLD_LIMIT_EN
    localparam logic [CW-1:0] c_hold_last = CW'(HOLD_LIMIT - 1);
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
`endif

    assign any_req  = req[0] | req[1] | req[2] | req[3];
    // Requests other than the current owner's.
    assign w_others = req & ~onehot(r_grant_id);

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_last_nxt     = r_last;
        w_revoke_nxt   = 1'b0;
        w_win          = 2'd0;
`ifdef RR_HOLD_LIMIT_EN
        w_cnt_nxt      = r_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (any_req) begin
                    w_win          = pick(r_last, req);
                    w_grant_nxt    = onehot(w_win);
                    w_grant_id_nxt = w_win;
                    w_last_nxt     = w_win;
                    w_state_nxt    = ST_GRANT;
`ifdef RR_HOLD_LIMIT_EN
                    w_cnt_nxt      = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (req[r_grant_id]) begin
`ifdef RR_HOLD_LIMIT_EN
                    if (r_cnt == c_hold_last) begin
                        // Limit reached: hand over only if someone is waiting,
                        // otherwise restart the window for the same owner.
                        w_cnt_nxt = '0;
                        if (|w_others) begin
                            w_win          = pick(r_grant_id, w_others);
                            w_grant_nxt    = onehot(w_win);
                            w_grant_id_nxt = w_win;
                            w_last_nxt     = w_win;
                            w_revoke_nxt   = 1'b1;
                        end
                    end else if (r_cnt != {CW{1'b1}}) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
`endif
                end else if (|w_others) begin
                    // Release with others waiting: back-to-back handover.
                    w_win          = pick(r_grant_id, req);
                    w_grant_nxt    = onehot(w_win);
                    w_grant_id_nxt = w_win;
                    w_last_nxt     = w_win;
`ifdef RR_HOLD_LIMIT_EN
                    w_cnt_nxt      = '0;
`endif
                end else begin
                    w_grant_nxt = 4'b0000;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_grant_nxt = 4'b0000;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_grant       <= 4'b0000;
            r_grant_id    <= 2'd0;
            r_grant_valid <= 1'b0;
            r_last        <= 2'd3;
            r_revoke      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_grant_valid <= |w_grant_nxt;
            r_last        <= w_last_nxt;
            r_revoke      <= w_revoke_nxt;
        end
    end

`ifdef RR_HOLD_LIMIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`endif

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign revoke      = r_revoke;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arbiter4
//  Purpose  : Directed self-checking bench for rr_arbiter4. Inputs change
//             1 ns after a rising edge; outputs are checked at the same point.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       any_req;
    logic       revoke;

    int n_total;
    int n_fail;

    rr_arbiter4 #(
        .HOLD_LIMIT(4),
        .CW        (8)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid),
        .any_req    (any_req),
        .revoke     (revoke)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Full output check: grant, its valid flag, owner id and revoke.
    task automatic chk_grant(input string tag, input logic [3:0] exp_g, input logic [1:0] exp_id,
                             input logic exp_rv);
        chk({tag, ".grant"}, grant, exp_g);
        chk({tag, ".valid"}, {3'b0, grant_valid}, {3'b0, (exp_g != 4'b0000)});
        if (exp_g != 4'b0000) chk({tag, ".id"}, {2'b0, grant_id}, {2'b0, exp_id});
        chk({tag, ".revoke"}, {3'b0, revoke}, {3'b0, exp_rv});
    endtask

    initial begin
        logic [3:0] oh;
        n_total = 0;
        n_fail  = 0;
        rst     = 1'b1;
        req     = 4'b1111;

        // Reset held two cycles with all requests high.
        step(); chk_grant("rst1", 4'b0000, 2'd0, 1'b0);
        step(); chk_grant("rst2", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        chk("any_req_1111", {3'b0, any_req}, 4'b0001);

        // Fair rotation: each owner holds 3 cycles, then releases.
        step();
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << (i % 4);
            chk_grant($sformatf("rot%0d_c1", i), oh, 2'(i % 4), 1'b0);
            req = 4'b1111;
            step(); chk_grant($sformatf("rot%0d_c2", i), oh, 2'(i % 4), 1'b0);
            step(); chk_grant($sformatf("rot%0d_c3", i), oh, 2'(i % 4), 1'b0);
            if (i < 4) begin
                req = 4'b1111 & ~oh;
                step();
            end
        end

        // Release with no other request -> idle.
        req = 4'b0000;
        #1 chk("any_req_0000", {3'b0, any_req}, 4'b0000);
        step(); chk_grant("idle", 4'b0000, 2'd0, 1'b0);

        // Single requester held 5 cycles, then released.
        req = 4'b0100;
        #1 chk("any_req_0100", {3'b0, any_req}, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            step(); chk_grant($sformatf("single%0d", i), 4'b0100, 2'd2, 1'b0);
        end
        req = 4'b0000;
        step(); chk_grant("single_rel", 4'b0000, 2'd0, 1'b0);

        // Owner 2 again; others arriving never preempt it.
        req = 4'b0100;
        step(); chk_grant("p2_grant", 4'b0100, 2'd2, 1'b0);
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step(); chk_grant($sformatf("nopreempt%0d", i), 4'b0100, 2'd2, 1'b0);
        end
        // Release with 1011 -> index 3 wins, not 0.
        req = 4'b1011;
        step(); chk_grant("ptr_3", 4'b1000, 2'd3, 1'b0);
        // Owner 3 releases -> scan wraps to 0.
        req = 4'b0111;
        step(); chk_grant("wrap_0", 4'b0001, 2'd0, 1'b0);
        // Owner 0 releases with only 1 waiting.
        req = 4'b0010;
        step(); chk_grant("to_1", 4'b0010, 2'd1, 1'b0);

        // Reset mid-grant drops the grant on the same edge.
        rst = 1'b1;
        step(); chk_grant("rst_mid", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        req = 4'b0000;
        step(); chk_grant("rst_idle", 4'b0000, 2'd0, 1'b0);
        // Pointer back at 3: requester 1 beats 2.
        req = 4'b0110;
        step(); chk_grant("rst_ptr", 4'b0010, 2'd1, 1'b0);
        req = 4'b0000;
        step(); chk_grant("rst_ptr_rel", 4'b0000, 2'd0, 1'b0);
        req = 4'b0011;
        step(); chk_grant("rst_0011", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        step();

`ifdef RR_HOLD_LIMIT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0011;
        step(); chk_grant("hl_0_c1", 4'b0001, 2'd0, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            step(); chk_grant($sformatf("hl_0_c%0d", i), 4'b0001, 2'd0, 1'b0);
        end
        step(); chk_grant("hl_rot1", 4'b0010, 2'd1, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            step(); chk_grant($sformatf("hl_1_c%0d", i), 4'b0010, 2'd1, 1'b0);
        end
        step(); chk_grant("hl_rot0", 4'b0001, 2'd0, 1'b1);
        req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step(); chk_grant($sformatf("hl_alone%0d", i), 4'b0001, 2'd0, 1'b0);
        end
        req = 4'b0000;
        step(); chk_grant("hl_rel", 4'b0000, 2'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
`default_nettype wire
